// File: rtl/cam_io_pkg.sv
// Shared types and helpers for the camera I/O conditioning blocks:
// trigger FSM state encoding, debounce counter width and a
// counter-width helper used to size internal counters.
package cam_io_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PULSE   = 2'd1,
      HOLDOFF = 2'd2
   } trig_state_t;

   localparam int DEB_CNT_W = 8;

   // Bits needed to hold the values 0..value-1 (at least 1 bit).
   function automatic int clog2(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/debounce_ch.sv
// One button channel: 2-FF synchroniser, tick-sampled stability counter,
// debounced level register and one-cycle rise/fall strobes that are
// asserted in the same cycle the level changes.
module debounce_ch
   import cam_io_pkg::*;
#(
   parameter int STABLE_CNT = 20,
   parameter bit RST_LEVEL  = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic btn,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(STABLE_CNT - 1);

   logic                 sync_d;
   logic                 sync_q;
   logic [DEB_CNT_W-1:0] cnt;

   // Synchronise the raw input, then on each tick count consecutive samples
   // that differ from the accepted level; any agreeing sample restarts.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_d <= RST_LEVEL;
         sync_q <= RST_LEVEL;
         cnt    <= '0;
         level  <= RST_LEVEL;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_d <= btn;
         sync_q <= sync_d;
         rise   <= 1'b0;
         fall   <= 1'b0;
         if (tick) begin
            if (sync_q == level) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               level <= ~level;
               cnt   <= '0;
               rise  <= ~level;
               fall  <= level;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/debounce_trig_ctrl.sv
// N-channel button conditioner with camera trigger pulse generator.
// A free-running divider produces the debounce sample tick; each channel
// is conditioned by debounce_ch; a rising edge on TRIG_CH or a soft
// trigger fires a fixed-width trig_out pulse followed by a hold-off.
// Optional build macro TRIG_DROP_CNT_EN adds drop_cnt, a saturating count
// of trigger requests ignored while the generator is busy.
module debounce_trig_ctrl
   import cam_io_pkg::*;
#(
   parameter int CLK_HZ         = 24000000,
   parameter int TICK_HZ        = 1000,
   parameter int N_CH           = 2,
   parameter int STABLE_CNT     = 20,
   parameter bit RST_LEVEL      = 1'b0,
   parameter int TRIG_CH        = 0,
   parameter int TRIG_PULSE_CYC = 24,
   parameter int HOLDOFF_CYC    = 2400
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_CH-1:0] btn_in,
   input  logic            sw_trig,
   output logic [N_CH-1:0] btn_level,
   output logic [N_CH-1:0] btn_rise,
   output logic [N_CH-1:0] btn_fall,
   output logic            trig_out,
   output logic            trig_busy
`ifdef TRIG_DROP_CNT_EN
   ,
   output logic [7:0]      drop_cnt
`endif
);

   localparam int TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int TICK_W   = clog2(TICK_DIV);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

   localparam int TMR_MAX = (TRIG_PULSE_CYC > HOLDOFF_CYC) ? TRIG_PULSE_CYC : HOLDOFF_CYC;
   localparam int TMR_W   = clog2(TMR_MAX);
   localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(TRIG_PULSE_CYC - 1);
   localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'((HOLDOFF_CYC > 0) ? (HOLDOFF_CYC - 1) : 0);

   logic [TICK_W-1:0] tick_cnt;
   logic              tick;
   logic              req;
   trig_state_t       state;
   logic [TMR_W-1:0]  timer;

   assign tick = (tick_cnt == TICK_LAST);
   assign req  = btn_rise[TRIG_CH] | sw_trig;

   // Shared sample-tick divider, wraps at TICK_DIV-1.
   always_ff @(posedge clk) begin
      if (!reset) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      debounce_ch #(
         .STABLE_CNT (STABLE_CNT),
         .RST_LEVEL  (RST_LEVEL)
      ) u_ch (
         .clk   (clk),
         .reset (reset),
         .tick  (tick),
         .btn   (btn_in[g]),
         .level (btn_level[g]),
         .rise  (btn_rise[g]),
         .fall  (btn_fall[g])
      );
   end

   // Trigger FSM with registered outputs; requests while busy are dropped.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         timer     <= '0;
         trig_out  <= 1'b0;
         trig_busy <= 1'b0;
`ifdef TRIG_DROP_CNT_EN
         drop_cnt  <= 8'd0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  state     <= PULSE;
                  timer     <= '0;
                  trig_out  <= 1'b1;
                  trig_busy <= 1'b1;
               end
            end
            PULSE: begin
               if (timer == PULSE_LAST) begin
                  trig_out <= 1'b0;
                  timer    <= '0;
                  if (HOLDOFF_CYC == 0) begin
                     state     <= IDLE;
                     trig_busy <= 1'b0;
                  end else begin
                     state <= HOLDOFF;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            HOLDOFF: begin
               if (timer == HOLD_LAST) begin
                  state     <= IDLE;
                  timer     <= '0;
                  trig_busy <= 1'b0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               timer     <= '0;
               trig_out  <= 1'b0;
               trig_busy <= 1'b0;
            end
         endcase
`ifdef TRIG_DROP_CNT_EN
         if ((state != IDLE) && req && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_debounce_trig_ctrl.sv
// Directed bench for debounce_trig_ctrl with TICK_DIV=10, STABLE_CNT=3,
// 4-cycle trigger pulse and 6-cycle hold-off on two channels.
module tb_debounce_trig_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] btn_in;
   logic       sw_trig;
   logic [1:0] btn_level;
   logic [1:0] btn_rise;
   logic [1:0] btn_fall;
   logic       trig_out;
   logic       trig_busy;
`ifdef TRIG_DROP_CNT_EN
   logic [7:0] drop_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   debounce_trig_ctrl #(
      .CLK_HZ         (1000),
      .TICK_HZ        (100),
      .N_CH           (2),
      .STABLE_CNT     (3),
      .RST_LEVEL      (1'b0),
      .TRIG_CH        (0),
      .TRIG_PULSE_CYC (4),
      .HOLDOFF_CYC    (6)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_in    (btn_in),
      .sw_trig   (sw_trig),
      .btn_level (btn_level),
      .btn_rise  (btn_rise),
      .btn_fall  (btn_fall),
      .trig_out  (trig_out),
      .trig_busy (trig_busy)
`ifdef TRIG_DROP_CNT_EN
      ,
      .drop_cnt  (drop_cnt)
`endif
   );

   task automatic wait_idle(input string tag);
      int cyc;
      cyc = 0;
      while (trig_busy !== 1'b0 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      n_cmp++;
      if (trig_busy !== 1'b0) begin
         n_err++;
         $display("FAIL %s_idle_timeout: trig_busy=%b want 0", tag, trig_busy);
      end
   endtask

   task automatic test_reset;
      int cyc;
      reset   = 1'b0;
      btn_in  = 2'b11;
      sw_trig = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({btn_level, btn_rise, btn_fall, trig_out, trig_busy} !== 8'b0) begin
            n_err++;
            $display("FAIL reset_outputs cyc%0d: got %b want 00000000", i,
                     {btn_level, btn_rise, btn_fall, trig_out, trig_busy});
         end
      end
`ifdef TRIG_DROP_CNT_EN
      n_cmp++;
      if (drop_cnt !== 8'd0) begin
         n_err++;
         $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt);
      end
`endif
      reset = 1'b1;
      cyc   = 0;
      while (btn_level === 2'b00 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      n_cmp++;
      if (cyc != 30) begin
         n_err++;
         $display("FAIL release_latency: got %0d cycles want 30", cyc);
      end
      n_cmp++;
      if (btn_level !== 2'b11 || btn_rise !== 2'b11) begin
         n_err++;
         $display("FAIL release_edge: level=%b rise=%b want 11/11", btn_level, btn_rise);
      end
      @(negedge clk);
      n_cmp++;
      if (btn_rise !== 2'b00 || trig_out !== 1'b1) begin
         n_err++;
         $display("FAIL release_trig: rise=%b trig_out=%b want 00/1", btn_rise, trig_out);
      end
      btn_in = 2'b00;
      cyc    = 0;
      while (btn_level !== 2'b00 && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
      n_cmp++;
      if (btn_level !== 2'b00 || btn_fall !== 2'b11) begin
         n_err++;
         $display("FAIL release_fall: level=%b fall=%b want 00/11", btn_level, btn_fall);
      end
      wait_idle("reset");
   endtask

   task automatic test_clean_press;
      int cyc;
      btn_in = 2'b01;
      cyc    = 0;
      while (btn_level[0] !== 1'b1 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         n_cmp++;
         if (btn_fall !== 2'b00) begin
            n_err++;
            $display("FAIL press_no_fall: fall=%b want 00", btn_fall);
         end
      end
      n_cmp++;
      if (cyc < 22 || cyc > 42) begin
         n_err++;
         $display("FAIL press_latency: got %0d cycles want 22..42", cyc);
      end
      n_cmp++;
      if (btn_level !== 2'b01 || btn_rise !== 2'b01) begin
         n_err++;
         $display("FAIL press_edge: level=%b rise=%b want 01/01", btn_level, btn_rise);
      end
      @(negedge clk);
      n_cmp++;
      if (btn_rise !== 2'b00 || trig_out !== 1'b1) begin
         n_err++;
         $display("FAIL press_rise_width: rise=%b trig_out=%b want 00/1", btn_rise, trig_out);
      end
      wait_idle("press");
      btn_in = 2'b00;
      cyc    = 0;
      while (btn_level[0] !== 1'b0 && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
      n_cmp++;
      if (btn_fall !== 2'b01 || btn_rise !== 2'b00) begin
         n_err++;
         $display("FAIL release_ch0: fall=%b rise=%b want 01/00", btn_fall, btn_rise);
      end
      @(negedge clk);
      n_cmp++;
      if (btn_fall !== 2'b00 || trig_out !== 1'b0) begin
         n_err++;
         $display("FAIL release_ch0_width: fall=%b trig_out=%b want 00/0", btn_fall, trig_out);
      end
   endtask

   task automatic test_glitch;
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < 90; i++) begin
         if (i < 20)      btn_in = 2'b10;
         else if (i < 30) btn_in = 2'b00;
         else if (i < 50) btn_in = 2'b10;
         else             btn_in = 2'b00;
         @(negedge clk);
         bad = bad | btn_level[1] | btn_rise[1] | btn_fall[1];
      end
      n_cmp++;
      if (bad !== 1'b0) begin
         n_err++;
         $display("FAIL glitch_reject: activity=%b want 0", bad);
      end
   endtask

   task automatic test_trig_pulse;
      logic [1:0] exp;
      sw_trig = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (i == 1) sw_trig = 1'b0;
         exp = {(i <= 4), (i <= 10)};
         n_cmp++;
         if ({trig_out, trig_busy} !== exp) begin
            n_err++;
            $display("FAIL trig_pulse cyc%0d: trig_out,busy=%b want %b", i, {trig_out, trig_busy}, exp);
         end
      end
   endtask

   task automatic test_collision;
      int cyc;
      logic [1:0] exp;
      btn_in = 2'b01;
      cyc    = 0;
      while (btn_rise[0] !== 1'b1 && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
      n_cmp++;
      if (btn_rise[0] !== 1'b1) begin
         n_err++;
         $display("FAIL collision_rise_timeout: rise=%b want 1", btn_rise[0]);
      end
      sw_trig = 1'b1;
      for (int i = 1; i <= 13; i++) begin
         @(negedge clk);
         if (i == 1) sw_trig = 1'b0;
         if (i == 6) sw_trig = 1'b1;
         if (i == 7) sw_trig = 1'b0;
         exp = {(i <= 4), (i <= 10)};
         n_cmp++;
         if ({trig_out, trig_busy} !== exp) begin
            n_err++;
            $display("FAIL collision cyc%0d: trig_out,busy=%b want %b", i, {trig_out, trig_busy}, exp);
         end
      end
`ifdef TRIG_DROP_CNT_EN
      n_cmp++;
      if (drop_cnt !== 8'd1) begin
         n_err++;
         $display("FAIL collision_drop_cnt: got %0d want 1", drop_cnt);
      end
`endif
      btn_in = 2'b00;
      cyc    = 0;
      while (btn_level[0] !== 1'b0 && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_back_to_back;
      logic [1:0] exp;
      sw_trig = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         if (i == 1)  sw_trig = 1'b0;
         if (i == 10) sw_trig = 1'b1;
         if (i == 12) sw_trig = 1'b0;
         exp = {((i <= 4) || (i >= 12 && i <= 15)), ((i <= 10) || (i >= 12))};
         n_cmp++;
         if ({trig_out, trig_busy} !== exp) begin
            n_err++;
            $display("FAIL back_to_back cyc%0d: trig_out,busy=%b want %b", i, {trig_out, trig_busy}, exp);
         end
      end
`ifdef TRIG_DROP_CNT_EN
      n_cmp++;
      if (drop_cnt !== 8'd2) begin
         n_err++;
         $display("FAIL back_to_back_drop_cnt: got %0d want 2", drop_cnt);
      end
`endif
      wait_idle("back_to_back");
   endtask

   task automatic test_mid_reset;
      logic [1:0] exp;
      sw_trig = 1'b1;
      @(negedge clk);
      sw_trig = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (trig_out !== 1'b1) begin
         n_err++;
         $display("FAIL mid_reset_pre: trig_out=%b want 1", trig_out);
      end
      reset = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({trig_out, trig_busy, btn_level} !== 4'b0000) begin
         n_err++;
         $display("FAIL mid_reset_drop: trig_out,busy,level=%b want 0000", {trig_out, trig_busy, btn_level});
      end
`ifdef TRIG_DROP_CNT_EN
      n_cmp++;
      if (drop_cnt !== 8'd0) begin
         n_err++;
         $display("FAIL mid_reset_drop_cnt: got %0d want 0", drop_cnt);
      end
`endif
      reset = 1'b1;
      @(negedge clk);
      sw_trig = 1'b1;
      for (int i = 1; i <= 11; i++) begin
         @(negedge clk);
         if (i == 1) sw_trig = 1'b0;
         exp = {(i <= 4), (i <= 10)};
         n_cmp++;
         if ({trig_out, trig_busy} !== exp) begin
            n_err++;
            $display("FAIL post_reset_pulse cyc%0d: trig_out,busy=%b want %b", i, {trig_out, trig_busy}, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_glitch();
      test_trig_pulse();
      test_collision();
      test_back_to_back();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
